// File: rtl/sram_axi_bridge.sv
// +--------------------------------------------------------------------------+
// | sram_axi_bridge: shares one AXI3 master between the fetch and data       |
// | SRAM-like ports; data reads win the read channel, stores use AW/W/B.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // data access port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rstate_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} wstate_t;

    rstate_t     r_rstate, w_rstate_nxt;
    wstate_t     r_wstate, w_wstate_nxt;
    logic [31:0] r_araddr;
    logic [1:0]  r_arsize;
    logic        r_ar_data;
    logic [31:0] r_awaddr;
    logic [1:0]  r_awsize;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;

    logic w_data_rd_acc, w_data_wr_acc, w_inst_acc;
    logic w_aw_fire, w_w_fire, w_r_fire, w_b_fire;

    // A load waits for any store in flight; a store waits for any load in flight.
    assign w_data_rd_acc = ~reset & data_sram_req & ~data_sram_wr
                           & (r_rstate == R_IDLE) & (r_wstate == W_IDLE);
    assign w_data_wr_acc = ~reset & data_sram_req & data_sram_wr & (r_wstate == W_IDLE)
                           & ~((r_rstate != R_IDLE) & r_ar_data);
    assign w_inst_acc    = ~reset & inst_sram_req & ~data_sram_req & (r_rstate == R_IDLE);

    assign w_aw_fire = awvalid & awready;
    assign w_w_fire  = wvalid & wready;
    assign w_r_fire  = ~reset & (r_rstate == R_R) & rvalid;
    assign w_b_fire  = ~reset & (r_wstate == W_B) & bvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_data_rd_acc || w_inst_acc) w_rstate_nxt = R_AR;
            R_AR:    if (arready)                     w_rstate_nxt = R_R;
            R_R:     if (rvalid)                      w_rstate_nxt = R_IDLE;
            default:                                  w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_data_wr_acc) w_wstate_nxt = W_REQ;
            W_REQ:   if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire))
                         w_wstate_nxt = W_B;
            W_B:     if (bvalid)        w_wstate_nxt = W_IDLE;
            default:                    w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_araddr  <= 32'd0;
            r_arsize  <= 2'd0;
            r_ar_data <= 1'b0;
            r_awaddr  <= 32'd0;
            r_awsize  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_data_rd_acc) begin
                r_araddr  <= data_sram_addr;
                r_arsize  <= data_sram_size;
                r_ar_data <= 1'b1;
            end else if (w_inst_acc) begin
                r_araddr  <= inst_sram_addr;
                r_arsize  <= inst_sram_size;
                r_ar_data <= 1'b0;
            end
            if (w_data_wr_acc) begin
                r_awaddr  <= data_sram_addr;
                r_awsize  <= data_sram_size;
                r_wdata   <= data_sram_wdata;
                r_wstrb   <= data_sram_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_wstate == W_REQ) begin
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
        end
    end

    assign inst_sram_addr_ok = w_inst_acc;
    assign data_sram_addr_ok = w_data_rd_acc | w_data_wr_acc;

    assign inst_sram_data_ok = w_r_fire & (rid == 4'd0);
    assign inst_sram_rdata   = inst_sram_data_ok ? rdata : 32'd0;
    assign data_sram_data_ok = (w_r_fire & (rid == 4'd1)) | w_b_fire;
    assign data_sram_rdata   = (w_r_fire & (rid == 4'd1)) ? rdata : 32'd0;

    assign arid    = {3'b000, r_ar_data};
    assign araddr  = r_araddr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_arsize};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_rstate == R_AR);
    assign rready  = (r_rstate == R_R);

    assign awid    = 4'd1;
    assign awaddr  = r_awaddr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, r_awsize};
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (r_wstate == W_REQ) & ~r_aw_done;

    assign wid    = 4'd1;
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;
    assign wlast  = 1'b1;
    assign wvalid = (r_wstate == W_REQ) & ~r_w_done;
    assign bready = (r_wstate == W_B);

    logic w_unused;
    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

endmodule

`default_nettype wire
